uart_rx: RTL and testbench
==========================

# uart_rx

- UART receiver that deserialises an asynchronous line into parallel words, LSB first, using 16x oversampling.
- Supports optional even/odd parity and reports parity and framing (stop-bit) errors.
- Sits at the pad side of the design and pairs with the UART transmitter, using the same frame: one start bit, P_data_width data bits, an optional parity bit, and one stop bit.
- Each received word is presented with a one-cycle DATA_VALID pulse.

## Interface
- CLK_freq, 100_000_000: master clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- P_data_width, 8: data bits per frame.
- OS_TICKS, CLK_freq/(BAUD_RATE*16): derived (integer division, truncated); master clocks per oversample tick; must be ≥1. Do not override.
- CLK  input  1  master clock; all logic on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- RX_IN  input  1  serial line; asynchronous; idles high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_data  output  P_data_width  last received word.
- DATA_VALID  output  1  one-cycle pulse when P_data and the error flags update.
- PAR_ERR  output  1  parity mismatch on the last word; 0 when PAR_EN was 0.
- STOP_ERR  output  1  stop bit sampled low on the last word.
- Busy  output  1  a frame is being received.

## Operation
- **Synchroniser:** RX_IN passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value (rx_s).
- **Tick generator:** a counter runs 0..OS_TICKS-1 and emits a tick on the terminal count. It is held at 0 in IDLE and starts on start-edge detection.
- **Sample counter:** s counts ticks 0..15 within each bit.
  - The decision point is s==8; s wraps 15→0 at the bit boundary.
  - Without the majority-vote option (see Configuration), the bit value is the rx_s sample taken at s==7.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** an rx_s 1→0 transition moves to START. On that transition PAR_EN and PAR_TYP are latched, Busy is set, and the tick and s counters are cleared.
  - **START:** at the decision point, a bit value of 1 is a false start: go to IDLE, clear Busy, no DATA_VALID. A value of 0 continues to DATA.
  - **DATA:** at each decision point, shift the bit value into a shift register (LSB first) and increment the bit index. After bit P_data_width-1, go to PARITY if latched PAR_EN, else go to STOP.
  - **PARITY:** at the decision point, compare the bit value with the expected parity (even: ^data; odd: ~^data), then go to STOP.
  - **STOP:** at the decision point:
    - P_data ← shift register.
    - PAR_ERR ← mismatch (0 if parity was disabled).
    - STOP_ERR ← ~bit value.
    - DATA_VALID pulses, Busy clears, and the FSM returns to IDLE.
- **Early rearm:** the receiver returns to IDLE at mid stop bit, so a start edge arriving right after the stop bit is caught.
- **Framing error:** after STOP_ERR the start detector is disarmed until rx_s has been seen high, so a stuck-low line does not produce back-to-back frames.
- **Errored words:** a word with errors is still delivered with DATA_VALID. The flags hold until the next DATA_VALID.
- **PAR_EN / PAR_TYP mid-frame:** changes are ignored until the next start edge.

## Timing
- **Reset values:** P_data=0, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0, Busy=0, state IDLE, synchroniser flops 1.
- **Reset mid-frame:** the partial word is discarded; no DATA_VALID is produced and P_data keeps its reset value of 0.
- **Input latency:** 2 CLK cycles from an RX_IN change to rx_s.
- **Start detect to Busy:** Busy rises on the cycle after the rx_s falling edge.
- **Tick k within a bit:** occurs (k+1)·OS_TICKS cycles after the bit start.
- **DATA_VALID:** asserted on the CLK cycle after the stop-bit decision tick, for exactly one cycle. P_data, PAR_ERR and STOP_ERR change in that same cycle.
- **Frame length:** (1+P_data_width+PAR_EN)·16·OS_TICKS + 9·OS_TICKS cycles from start edge to the decision point that produces DATA_VALID.

## Configuration
- **UART_RX_MAJORITY_VOTE_EN defined:** the bit value is the 2-of-3 majority of rx_s at s==6, 7 and 8, evaluated at s==8. Single-cycle glitches at one sample point are rejected.
- **Not defined:** the single sample at s==7 is used; the vote logic is absent.
- Decision timing is identical in both builds.

## Test plan
Common setup: CLK_freq=16_000_000, BAUD_RATE=1_000_000 (OS_TICKS=1, 16 cycles per bit), P_data_width=8.

- **Basic frame:** PAR_EN=0, line sends 0xA5 with stop=1 → one DATA_VALID pulse; P_data=0xA5, PAR_ERR=0, STOP_ERR=0; Busy high from start edge to DATA_VALID.
- **Parity:**
  - PAR_EN=1, PAR_TYP=0, 0x03 with parity bit 0 → PAR_ERR=0.
  - Same with parity bit 1 → PAR_ERR=1, P_data=0x03.
  - PAR_TYP=1, 0x01 with parity bit 0 → PAR_ERR=0.
- **False start:** 4-cycle low pulse in IDLE → no DATA_VALID; Busy returns to 0 within 10 cycles of the edge.
- **Framing error:** 0x5A with stop=0, line held low for 40 more cycles, then high, then 0x3C → STOP_ERR=1 with P_data=0x5A. The next DATA_VALID has P_data=0x3C, STOP_ERR=0, with no spurious frame in between.
- **Back-to-back:** 0x11 then 0x22 with no idle gap → two DATA_VALID pulses 160 cycles apart, both error-free.
- **Reset mid-frame:** RST pulsed during bit 4 of 0xFF → outputs return to 0 immediately; no DATA_VALID; the following frame 0x81 is received correctly.
- **Majority vote (UART_RX_MAJORITY_VOTE_EN only):** 1-cycle high glitch at s==7 of a data-0 bit → bit received as 0.

Source files
------------

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with optional parity and framing checks.
// Build option: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting at s==6/7/8.
module uart_rx #(
  parameter int CLK_freq     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int P_data_width = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_IN,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  output logic [P_data_width-1:0] P_data,
  output logic                    DATA_VALID,
  output logic                    PAR_ERR,
  output logic                    STOP_ERR,
  output logic                    Busy
);

  localparam int OS_TICKS = CLK_freq / (BAUD_RATE * 16);
  localparam int TW = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;
  localparam int IW = $clog2(P_data_width + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS_TICKS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(P_data_width - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, next;

  logic sync1, rx_s, rx_d, armed;
  logic [TW-1:0] tcnt;
  logic [3:0] s;
  logic [IW-1:0] bit_idx;
  logic [P_data_width-1:0] shreg;
  logic par_en_q, par_typ_q, par_mis;
  logic samp7, bit_val, tick, decide;
  logic start, shift, chk_par, done;
  logic exp_par;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp6;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp6 <= 1'b1;
    end else if (tick && s == 4'd6) begin
      samp6 <= rx_s;
    end
  end

  assign bit_val = (samp6 & samp7) | (samp6 & rx_s) | (samp7 & rx_s);
`else
  assign bit_val = samp7;
`endif

  assign tick    = (state != IDLE) && (tcnt == T_LAST);
  assign decide  = tick && (s == 4'd8);
  assign exp_par = par_typ_q ? ~^shreg : ^shreg;
  assign Busy    = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next    = state;
    start   = 1'b0;
    shift   = 1'b0;
    chk_par = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && rx_d && !rx_s) begin
          next  = START;
          start = 1'b1;
        end
      end
      START: begin
        if (decide) begin
          next = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift = 1'b1;
          if (bit_idx == I_LAST) begin
            next = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (decide) begin
          chk_par = 1'b1;
          next    = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          done = 1'b1;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      armed      <= 1'b1;
      tcnt       <= '0;
      s          <= '0;
      samp7      <= 1'b1;
      bit_idx    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_mis    <= 1'b0;
      P_data     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
    end else begin
      sync1      <= RX_IN;
      rx_s       <= sync1;
      rx_d       <= rx_s;
      DATA_VALID <= done;
      // a low stop bit disarms start detection until the line idles high
      if (done && !bit_val) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end
      if (state == IDLE || tick) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (start) begin
        s         <= '0;
        bit_idx   <= '0;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_mis   <= 1'b0;
      end else if (tick) begin
        s <= s + 1'b1;
      end
      if (tick && s == 4'd7) begin
        samp7 <= rx_s;
      end
      if (shift) begin
        shreg   <= {bit_val, shreg[P_data_width-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (chk_par) begin
        par_mis <= (bit_val != exp_par);
      end
      if (done) begin
        P_data   <= shreg;
        PAR_ERR  <= par_en_q & par_mis;
        STOP_ERR <= ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Table of frames plus sequences for false start, framing, reset, back-to-back.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_data;
  logic       DATA_VALID, PAR_ERR, STOP_ERR, Busy;

  uart_rx #(
    .CLK_freq(16_000_000),
    .BAUD_RATE(1_000_000),
    .P_data_width(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .P_data(P_data),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR),
    .STOP_ERR(STOP_ERR),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  int dv_cnt = 0;
  int cap_cyc = 0;
  int prev_cyc = 0;
  logic [7:0] cap_data = '0;
  logic [7:0] prev_data = '0;
  logic cap_perr = 1'b0;
  logic cap_serr = 1'b0;
  logic dv_last = 1'b0;
  logic dv_multi = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    dv_last <= DATA_VALID;
    if (DATA_VALID && dv_last) dv_multi <= 1'b1;
    if (DATA_VALID && !dv_last) begin
      dv_cnt    <= dv_cnt + 1;
      prev_cyc  <= cap_cyc;
      prev_data <= cap_data;
      cap_cyc   <= cyc;
      cap_data  <= P_data;
      cap_perr  <= PAR_ERR;
      cap_serr  <= STOP_ERR;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bitc(input logic v);
    RX_IN = v;
    repeat (16) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe,
                            input logic pt, input logic pb,
                            input logic sb);
    PAR_EN  = pe;
    PAR_TYP = pt;
    RX_IN   = 1'b0;
    c0      = cyc;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("busy_pre", Busy, 0);
    @(negedge CLK);
    chk("busy_rise", Busy, 1);
    repeat (13) @(posedge CLK);
    #1;
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
    for (int i = 0; i < 8; i++) bitc(d[i]);
    if (pe) bitc(pb);
    bitc(sb);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       pb;
    logic       sb;
    logic [7:0] xd;
    logic       xpe;
    logic       xse;
  } vec_t;

  vec_t v[8];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int lat;
    int drop;
    logic hi;

    v[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    v[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    v[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    v[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    v[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    v[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    v[6] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    v[7] = '{8'h5F, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5F, 1'b1, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", P_data, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_perr", PAR_ERR, 0);
    chk("rst_serr", STOP_ERR, 0);
    chk("rst_busy", Busy, 0);

    for (int k = 0; k < 8; k++) begin
      n0 = dv_cnt;
      send_frame(v[k].d, v[k].pe, v[k].pt, v[k].pb, v[k].sb);
      idle(4);
      lat = (9 + int'(v[k].pe)) * 16 + 12;
      chk("vec_dv_count", dv_cnt, n0 + 1);
      chk("vec_data", cap_data, v[k].xd);
      chk("vec_perr", cap_perr, v[k].xpe);
      chk("vec_serr", cap_serr, v[k].xse);
      chk("vec_latency", cap_cyc - c0, lat);
      chk("vec_busy_end", Busy, 0);
    end

    n0 = dv_cnt;
    RX_IN = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (72) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_data", P_data, 0);
    chk("midrst_perr", PAR_ERR, 0);
    chk("midrst_serr", STOP_ERR, 0);
    chk("midrst_busy", Busy, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(100);
    chk("midrst_no_dv", dv_cnt, n0);
    chk("midrst_data_held", P_data, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("after_rst_count", dv_cnt, n0 + 1);
    chk("after_rst_data", cap_data, 8'h81);
    chk("after_rst_serr", cap_serr, 0);

    n0   = dv_cnt;
    hi   = 1'b0;
    drop = 0;
    RX_IN = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 5) RX_IN = 1'b1;
      if (Busy) hi = 1'b1;
      else if (hi && drop == 0) drop = i;
    end
    @(posedge CLK);
    #1;
    idle(30);
    chk("fs_busy_seen", hi, 1);
    chk("fs_busy_drop", drop, 13);
    chk("fs_no_dv", dv_cnt, n0);

    n0 = dv_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge CLK);
    #1;
    chk("fe_count", dv_cnt, n0 + 1);
    chk("fe_data", cap_data, 8'h5A);
    chk("fe_serr", cap_serr, 1);
    chk("fe_serr_hold", STOP_ERR, 1);
    idle(20);
    chk("fe_no_spurious", dv_cnt, n0 + 1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("fe_next_count", dv_cnt, n0 + 2);
    chk("fe_next_data", cap_data, 8'h3C);
    chk("fe_next_serr", cap_serr, 0);

    n0 = dv_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("b2b_count", dv_cnt, n0 + 2);
    chk("b2b_first", prev_data, 8'h11);
    chk("b2b_second", cap_data, 8'h22);
    chk("b2b_gap", cap_cyc - prev_cyc, 160);
    chk("b2b_perr", cap_perr, 0);
    chk("b2b_serr", cap_serr, 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    n0 = dv_cnt;
    PAR_EN = 1'b0;
    RX_IN  = 1'b0;
    repeat (24) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    RX_IN = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    for (int i = 1; i < 8; i++) bitc(1'b0);
    bitc(1'b1);
    idle(4);
    chk("mv_count", dv_cnt, n0 + 1);
    chk("mv_data", cap_data, 8'h00);
`endif

    chk("dv_one_cycle", dv_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
